tia_object_position_counter: RTL and testbench



---
 rtl/tia_pkg.sv | 27 ++
 rtl/tia_copy_decode.sv | 47 ++++
 rtl/tia_object_position_counter.sv | 94 +++++++++
 tb/tb_tia_object_position_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tia_pkg.sv
// Shared constants and types for the TIA object position counters.
// Holds the line period, NUSIZ copy codes, copy offsets and counter widths.
package tia_pkg;

    localparam int PERIOD_160 = 160;
    localparam int POS_W      = 8;
    localparam int EC_W       = 5;

    localparam logic [2:0] NUSIZ_ONE         = 3'b000;
    localparam logic [2:0] NUSIZ_TWO_CLOSE   = 3'b001;
    localparam logic [2:0] NUSIZ_TWO_MED     = 3'b010;
    localparam logic [2:0] NUSIZ_THREE_CLOSE = 3'b011;
    localparam logic [2:0] NUSIZ_TWO_WIDE    = 3'b100;
    localparam logic [2:0] NUSIZ_DOUBLE      = 3'b101;
    localparam logic [2:0] NUSIZ_THREE_MED   = 3'b110;
    localparam logic [2:0] NUSIZ_QUAD        = 3'b111;

    localparam int OFS_CLOSE = 16;
    localparam int OFS_MED   = 32;
    localparam int OFS_WIDE  = 64;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } start_dec_t;

endpackage

// File: rtl/tia_copy_decode.sv
// Combinational start-position decode: maps the position being entered,
// the NUSIZ copy field and the main-copy suppress flag to {hit, copy index}.
module tia_copy_decode
    import tia_pkg::*;
#(
    parameter bit HAS_COPIES = 1'b1
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic [2:0]       copies_i,
    input  logic             suppress_i,
    output start_dec_t       dec_o
);

    logic [2:0] cp;

    always_comb begin
        cp    = HAS_COPIES ? copies_i : NUSIZ_ONE;
        dec_o = '0;
        if (pos_i == '0) begin
            dec_o.hit = ~suppress_i;
            dec_o.idx = 2'd0;
        end else if (pos_i == POS_W'(OFS_CLOSE)) begin
            if (cp == NUSIZ_TWO_CLOSE || cp == NUSIZ_THREE_CLOSE) begin
                dec_o.hit = 1'b1;
                dec_o.idx = 2'd1;
            end
        end else if (pos_i == POS_W'(OFS_MED)) begin
            // The ordinal depends on whether a closer copy precedes this one.
            if (cp == NUSIZ_TWO_MED || cp == NUSIZ_THREE_MED) begin
                dec_o.hit = 1'b1;
                dec_o.idx = 2'd1;
            end else if (cp == NUSIZ_THREE_CLOSE) begin
                dec_o.hit = 1'b1;
                dec_o.idx = 2'd2;
            end
        end else if (pos_i == POS_W'(OFS_WIDE)) begin
            if (cp == NUSIZ_TWO_WIDE) begin
                dec_o.hit = 1'b1;
                dec_o.idx = 2'd1;
            end else if (cp == NUSIZ_THREE_MED) begin
                dec_o.hit = 1'b1;
                dec_o.idx = 2'd2;
            end
        end
    end

endmodule

// File: rtl/tia_object_position_counter.sv
// Per-object horizontal position counter: advances on motion clock or extra
// clock, wraps modulo PERIOD, and emits registered copy start strobes.
module tia_object_position_counter
    import tia_pkg::*;
#(
    parameter int PERIOD     = PERIOD_160,
    parameter int RESP_LOAD  = 0,
    parameter bit HAS_COPIES = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_bar_i,
    input  logic             motck_i,
    input  logic             ec_bar_i,
    input  logic             resp_i,
    input  logic             sec_i,
    input  logic [2:0]       copies_i,
    output logic [POS_W-1:0] pos_o,
    output logic             start_o,
    output logic [1:0]       copy_idx_o,
    output logic [EC_W-1:0]  ec_count_o
);

    logic [POS_W-1:0] pos_q, pos_d, pos_inc;
    logic             suppress_q, suppress_d, sup_inc;
    logic             start_q, start_d;
    logic [1:0]       copy_idx_q, copy_idx_d;
    logic [EC_W-1:0]  ec_q, ec_d;
    logic             ec_req, adv, wrap;
    start_dec_t       dec;

    assign ec_req = (ec_bar_i == 1'b0);
    assign adv    = motck_i | ec_req;
    assign wrap   = (pos_q == POS_W'(PERIOD - 1));

    // Decode looks at the position and suppress state an advance would produce.
    assign pos_inc = wrap ? '0 : pos_q + POS_W'(1);
    assign sup_inc = wrap ? 1'b0 : suppress_q;

    tia_copy_decode #(
        .HAS_COPIES (HAS_COPIES)
    ) u_dec (
        .pos_i      (pos_inc),
        .copies_i   (copies_i),
        .suppress_i (sup_inc),
        .dec_o      (dec)
    );

    always_comb begin
        pos_d      = pos_q;
        suppress_d = suppress_q;
        start_d    = 1'b0;
        copy_idx_d = copy_idx_q;
        if (resp_i) begin
            pos_d      = POS_W'(RESP_LOAD);
            suppress_d = 1'b1;
        end else if (adv) begin
            pos_d      = pos_inc;
            suppress_d = sup_inc;
            start_d    = dec.hit;
            if (dec.hit) copy_idx_d = dec.idx;
        end
    end

    // Extra-clock tally saturates; a pulse coincident with sec counts as the first.
    always_comb begin
        ec_d = ec_q;
        if (sec_i)
            ec_d = ec_req ? EC_W'(1) : '0;
        else if (ec_req && ec_q != '1)
            ec_d = ec_q + EC_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_bar_i) begin
            pos_q      <= '0;
            suppress_q <= 1'b1;
            start_q    <= 1'b0;
            copy_idx_q <= 2'd0;
            ec_q       <= '0;
        end else begin
            pos_q      <= pos_d;
            suppress_q <= suppress_d;
            start_q    <= start_d;
            copy_idx_q <= copy_idx_d;
            ec_q       <= ec_d;
        end
    end

    assign pos_o      = pos_q;
    assign start_o    = start_q;
    assign copy_idx_o = copy_idx_q;
    assign ec_count_o = ec_q;

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Directed bench for the object position counter: reset, free run, copies,
// RESP, HMOVE extra clocks, coincident advance, and reset mid-HMOVE.
module tb_tia_object_position_counter;

    logic       clk = 1'b0;
    logic       reset_bar, motck, ec_bar, resp, sec;
    logic [2:0] copies;
    logic [7:0] pos;
    logic       start;
    logic [1:0] copy_idx;
    logic [4:0] ec_count;

    int vec  = 0;
    int miss = 0;

    tia_object_position_counter dut (
        .clk_i       (clk),
        .reset_bar_i (reset_bar),
        .motck_i     (motck),
        .ec_bar_i    (ec_bar),
        .resp_i      (resp),
        .sec_i       (sec),
        .copies_i    (copies),
        .pos_o       (pos),
        .start_o     (start),
        .copy_idx_o  (copy_idx),
        .ec_count_o  (ec_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_bar = 1'b0; motck = 1'b1; ec_bar = 1'b0; resp = 1'b0;
        sec = 1'b0; copies = 3'b011;
        tick(); tick();
        vec++; if (pos !== 8'd0)      begin miss++; $display("FAIL reset_pos: got %0d want 0", pos); end
        vec++; if (start !== 1'b0)    begin miss++; $display("FAIL reset_start: got %0b want 0", start); end
        vec++; if (copy_idx !== 2'd0) begin miss++; $display("FAIL reset_idx: got %0d want 0", copy_idx); end
        vec++; if (ec_count !== 5'd0) begin miss++; $display("FAIL reset_ec: got %0d want 0", ec_count); end
        ec_bar = 1'b1; copies = 3'b000; reset_bar = 1'b1;
    endtask

    // Starts from pos 0 just out of reset; ends at pos 10.
    task automatic test_free_run();
        int n = 0, s1 = -1, s2 = -1;
        for (int k = 1; k <= 330; k++) begin
            tick();
            if (start) begin
                n++;
                if (s1 < 0) s1 = k; else if (s2 < 0) s2 = k;
            end
            if (k == 159) begin
                vec++; if (pos !== 8'd159) begin miss++; $display("FAIL free_pos159: got %0d want 159", pos); end
            end
            if (k == 160) begin
                vec++; if (pos !== 8'd0) begin miss++; $display("FAIL free_wrap: got %0d want 0", pos); end
            end
        end
        vec++; if (s1 != 160) begin miss++; $display("FAIL free_first_start: got %0d want 160", s1); end
        vec++; if (s2 != 320) begin miss++; $display("FAIL free_second_start: got %0d want 320", s2); end
        vec++; if (n != 2)    begin miss++; $display("FAIL free_start_count: got %0d want 2", n); end
    endtask

    // Runs one full line from pos 10 and compares the start sequence.
    task automatic run_line(input logic [2:0] cp, input int exp_n,
                            input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] i2);
        logic [7:0] sp [3];
        logic [1:0] si [3];
        int n = 0;
        copies = cp;
        for (int k = 0; k < 160; k++) begin
            tick();
            if (start) begin
                if (n < 3) begin sp[n] = pos; si[n] = copy_idx; end
                n++;
            end
        end
        vec++; if (n != exp_n) begin miss++; $display("FAIL copies_%b_count: got %0d want %0d", cp, n, exp_n); end
        if (exp_n == 3 && n == 3) begin
            vec++; if (sp[0] !== p0 || si[0] !== i0) begin miss++; $display("FAIL copies_%b_first: got pos %0d idx %0d want pos %0d idx %0d", cp, sp[0], si[0], p0, i0); end
            vec++; if (sp[1] !== p1 || si[1] !== i1) begin miss++; $display("FAIL copies_%b_second: got pos %0d idx %0d want pos %0d idx %0d", cp, sp[1], si[1], p1, i1); end
            vec++; if (sp[2] !== p2 || si[2] !== i2) begin miss++; $display("FAIL copies_%b_third: got pos %0d idx %0d want pos %0d idx %0d", cp, sp[2], si[2], p2, i2); end
        end
    endtask

    task automatic test_copies();
        run_line(3'b011, 3, 8'd16, 8'd32, 8'd0, 2'd1, 2'd2, 2'd0);
        run_line(3'b110, 3, 8'd32, 8'd64, 8'd0, 2'd1, 2'd2, 2'd0);
        run_line(3'b101, 1, 8'd0, 8'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    endtask

    // From pos 10: advance to 77, RESP, then copies=001.
    task automatic test_resp();
        int n = 0, s1 = -1, s2 = -1;
        logic [7:0] p1 = 8'hff;
        logic [1:0] i1 = 2'd3;
        for (int k = 0; k < 67; k++) tick();
        vec++; if (pos !== 8'd77) begin miss++; $display("FAIL resp_pre_pos: got %0d want 77", pos); end
        resp = 1'b1;
        tick();
        resp = 1'b0; copies = 3'b001;
        vec++; if (pos !== 8'd0)   begin miss++; $display("FAIL resp_pos: got %0d want 0", pos); end
        vec++; if (start !== 1'b0) begin miss++; $display("FAIL resp_start: got %0b want 0", start); end
        for (int k = 1; k <= 170; k++) begin
            tick();
            if (start) begin
                n++;
                if (s1 < 0) begin s1 = k; p1 = pos; i1 = copy_idx; end
                else if (s2 < 0) s2 = k;
            end
        end
        vec++; if (s1 != 16 || p1 !== 8'd16 || i1 !== 2'd1) begin miss++; $display("FAIL resp_copy16: got edge %0d pos %0d idx %0d want edge 16 pos 16 idx 1", s1, p1, i1); end
        vec++; if (s2 != 160) begin miss++; $display("FAIL resp_main_after_wrap: got %0d want 160", s2); end
        vec++; if (n != 2)    begin miss++; $display("FAIL resp_start_count: got %0d want 2", n); end
    endtask

    // From pos 10: 68-cycle HBLANK with 15 extra clocks after sec.
    task automatic test_hmove();
        int d = 0;
        copies = 3'b000; motck = 1'b0; sec = 1'b1; ec_bar = 1'b1;
        tick();
        sec = 1'b0;
        vec++; if (ec_count !== 5'd0) begin miss++; $display("FAIL hmove_sec_clear: got %0d want 0", ec_count); end
        for (int k = 1; k < 68; k++) begin
            ec_bar = (k <= 15) ? 1'b0 : 1'b1;
            tick();
        end
        ec_bar = 1'b1;
        vec++; if (pos !== 8'd25)      begin miss++; $display("FAIL hmove_pos: got %0d want 25", pos); end
        vec++; if (ec_count !== 5'd15) begin miss++; $display("FAIL hmove_ec: got %0d want 15", ec_count); end
        motck = 1'b1;
        while (d < 200) begin
            tick();
            d++;
            if (start) break;
        end
        vec++; if (d != 135)      begin miss++; $display("FAIL hmove_start_dist: got %0d want 135", d); end
        vec++; if (pos !== 8'd0)  begin miss++; $display("FAIL hmove_start_pos: got %0d want 0", pos); end
    endtask

    // From pos 0: coincident advance, sec with ec, and saturation.
    task automatic test_back_to_back();
        motck = 1'b1; ec_bar = 1'b1; sec = 1'b1;
        tick();
        sec = 1'b0; ec_bar = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        vec++; if (pos !== 8'd11)      begin miss++; $display("FAIL both_pos: got %0d want 11", pos); end
        vec++; if (ec_count !== 5'd10) begin miss++; $display("FAIL both_ec: got %0d want 10", ec_count); end
        sec = 1'b1;
        tick();
        sec = 1'b0;
        vec++; if (ec_count !== 5'd1)  begin miss++; $display("FAIL sec_with_ec: got %0d want 1", ec_count); end
        motck = 1'b0;
        for (int k = 0; k < 35; k++) tick();
        vec++; if (ec_count !== 5'd31) begin miss++; $display("FAIL ec_saturate: got %0d want 31", ec_count); end
        vec++; if (pos !== 8'd47)      begin miss++; $display("FAIL ec_only_pos: got %0d want 47", pos); end
        ec_bar = 1'b1;
    endtask

    // From pos 47: set up pos 140 with ec_count 6, then reset.
    task automatic test_reset_mid_hmove();
        motck = 1'b1; ec_bar = 1'b1; sec = 1'b1;
        tick();
        sec = 1'b0;
        for (int k = 0; k < 86; k++) tick();
        motck = 1'b0; ec_bar = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        vec++; if (pos !== 8'd140 || ec_count !== 5'd6) begin miss++; $display("FAIL midhm_setup: got pos %0d ec %0d want pos 140 ec 6", pos, ec_count); end
        reset_bar = 1'b0;
        tick();
        reset_bar = 1'b1;
        vec++; if (pos !== 8'd0 || ec_count !== 5'd0 || start !== 1'b0) begin miss++; $display("FAIL midhm_reset: got pos %0d ec %0d start %0b want 0 0 0", pos, ec_count, start); end
        for (int k = 0; k < 3; k++) tick();
        vec++; if (pos !== 8'd3 || ec_count !== 5'd3) begin miss++; $display("FAIL midhm_resume: got pos %0d ec %0d want pos 3 ec 3", pos, ec_count); end
        ec_bar = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_copies();
        test_resp();
        test_hmove();
        test_back_to_back();
        test_reset_mid_hmove();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
